// File: rtl/lc3_mem_arb_if.sv
// Bus bundle for lc3_mem_arb: CPU (MAR/MDR) port, DMA/loader port and memory-array port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface lc3_mem_arb_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ready;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] dma_rdata;
    logic          dma_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lc3_mem_arb.sv
// LC-3 single-port memory arbiter (CPU vs DMA, round-robin) with programmable wait states.
// Optional user-mode access-control violation check enabled by defining LC3_MEM_ACV_EN.
module lc3_mem_arb #(
    parameter int WAIT_STATES = 2,
    parameter int AW          = 16,
    parameter int DW          = 16
) (
    input logic          clk,
    input logic          rst,
    lc3_mem_arb_if.slave bus
`ifdef LC3_MEM_ACV_EN
    ,
    input  logic         psr_user,
    output logic         acv
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } owner_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES);

    state_t        state;
    owner_t        owner;
    owner_t        last_grant;
    logic [3:0]    cnt;

    owner_t        pick;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          violation;

    always_comb begin
        pick      = OWN_CPU;
        sel_we    = bus.cpu_we;
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        if (bus.cpu_req && bus.dma_req) begin
            pick = (last_grant == OWN_CPU) ? OWN_DMA : OWN_CPU;
        end else if (bus.dma_req) begin
            pick = OWN_DMA;
        end
        if (pick == OWN_DMA) begin
            sel_we    = bus.dma_we;
            sel_addr  = bus.dma_addr;
            sel_wdata = bus.dma_wdata;
        end
    end

`ifdef LC3_MEM_ACV_EN
    // System space (x0000-x2FFF) and device registers (xFE00-xFFFF) are privileged.
    always_comb begin
        violation = (pick == OWN_CPU) && psr_user &&
                    ((bus.cpu_addr <= AW'(16'h2FFF)) || (bus.cpu_addr >= AW'(16'hFE00)));
    end
`else
    always_comb begin
        violation = 1'b0;
    end
`endif

    // mem_we/mem_addr/mem_wdata double as the grant-time latches of the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            owner         <= OWN_CPU;
            last_grant    <= OWN_DMA;
            bus.cpu_rdata <= '0;
            bus.cpu_ready <= 1'b0;
            bus.dma_rdata <= '0;
            bus.dma_ack   <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
`ifdef LC3_MEM_ACV_EN
            acv           <= 1'b0;
`endif
        end else begin
            bus.cpu_ready <= 1'b0;
            bus.dma_ack   <= 1'b0;
`ifdef LC3_MEM_ACV_EN
            acv           <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (bus.cpu_req || bus.dma_req) begin
                        owner      <= pick;
                        last_grant <= pick;
                        cnt        <= '0;
                        if (violation) begin
                            state         <= RESP;
                            bus.cpu_rdata <= '0;
                            bus.cpu_ready <= 1'b1;
`ifdef LC3_MEM_ACV_EN
                            acv           <= 1'b1;
`endif
                        end else begin
                            state         <= ACCESS;
                            bus.mem_en    <= 1'b1;
                            bus.mem_we    <= sel_we;
                            bus.mem_addr  <= sel_addr;
                            bus.mem_wdata <= sel_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == LAST_CNT) begin
                        state         <= RESP;
                        bus.mem_en    <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= '0;
                        bus.mem_wdata <= '0;
                        if (owner == OWN_DMA) begin
                            bus.dma_ack <= 1'b1;
                            if (!bus.mem_we) begin
                                bus.dma_rdata <= bus.mem_rdata;
                            end
                        end else begin
                            bus.cpu_ready <= 1'b1;
                            if (!bus.mem_we) begin
                                bus.cpu_rdata <= bus.mem_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_arb.sv
// Self-checking bench for lc3_mem_arb: directed vector table, corner sequences and
// randomized transactions against a transaction-level reference model.
module tb_lc3_mem_arb;

    localparam int unsigned WS = 2;

    logic clk;
    logic rst;
`ifdef LC3_MEM_ACV_EN
    logic psr_user;
    logic acv;
`endif

    lc3_mem_arb_if #(.AW(16), .DW(16)) bus ();

    lc3_mem_arb #(
        .WAIT_STATES(WS),
        .AW(16),
        .DW(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef LC3_MEM_ACV_EN
        ,
        .psr_user(psr_user),
        .acv(acv)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory array: unwritten locations return a fixed address pattern.
    function automatic logic [15:0] pat(input logic [15:0] a);
        logic [15:0] t;
        t = a - 16'h3000;
        return t * 16'h0101 + 16'h1234;
    endfunction

    logic [15:0] mem_arr [256];
    logic        wr_valid [256] = '{default: 1'b0};

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            mem_arr[bus.mem_addr[7:0]]  <= bus.mem_wdata;
            wr_valid[bus.mem_addr[7:0]] <= 1'b1;
        end
    end

    assign bus.mem_rdata = wr_valid[bus.mem_addr[7:0]] ? mem_arr[bus.mem_addr[7:0]]
                                                       : pat(bus.mem_addr);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [15:0] addr,
                           input logic [15:0] wd);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [15:0] addr,
                           input logic [15:0] wd);
        bus.dma_req   = req;
        bus.dma_we    = we;
        bus.dma_addr  = addr;
        bus.dma_wdata = wd;
    endtask

    task automatic drop_reqs();
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
    endtask

    task automatic do_reset();
        drop_reqs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Called in an IDLE cycle with requests applied; returns in the following IDLE cycle.
    task automatic run_txn(input string tag, input logic e_dma, input logic e_we,
                           input logic [15:0] e_addr, input logic [15:0] e_wd,
                           input logic [15:0] e_rd);
        for (int unsigned i = 0; i <= WS; i++) begin
            tick();
            if (i == 0) drop_reqs();
            chk({tag, "/en"}, 32'(bus.mem_en), 32'd1);
            chk({tag, "/we"}, 32'(bus.mem_we), 32'(e_we));
            chk({tag, "/addr"}, 32'(bus.mem_addr), 32'(e_addr));
            chk({tag, "/wdata"}, 32'(bus.mem_wdata), 32'(e_wd));
            chk({tag, "/early_done"}, 32'(bus.cpu_ready | bus.dma_ack), 32'd0);
        end
        tick();
        chk({tag, "/resp_en"}, 32'(bus.mem_en), 32'd0);
        chk({tag, "/cpu_ready"}, 32'(bus.cpu_ready), 32'(!e_dma));
        chk({tag, "/dma_ack"}, 32'(bus.dma_ack), 32'(e_dma));
        chk({tag, "/rdata"}, 32'(e_dma ? bus.dma_rdata : bus.cpu_rdata), 32'(e_rd));
`ifdef LC3_MEM_ACV_EN
        chk({tag, "/acv"}, 32'(acv), 32'd0);
`endif
        tick();
        chk({tag, "/idle_done"}, 32'(bus.cpu_ready | bus.dma_ack), 32'd0);
        chk({tag, "/idle_en"}, 32'(bus.mem_en), 32'd0);
    endtask

    typedef struct {
        logic        c_req;
        logic        c_we;
        logic [15:0] c_addr;
        logic [15:0] c_wd;
        logic        d_req;
        logic        d_we;
        logic [15:0] d_addr;
        logic [15:0] d_wd;
        logic        e_dma;
        logic        e_we;
        logic [15:0] e_addr;
        logic [15:0] e_wd;
        logic [15:0] e_rd;
    } vec_t;

    vec_t vecs [8];

    logic [15:0] m_mem [logic [15:0]];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          last;
        logic        exp_dma;
        logic        m_last_dma;
        logic [15:0] m_cpu_rd;
        logic [15:0] m_dma_rd;

        // {c_req,c_we,c_addr,c_wd, d_req,d_we,d_addr,d_wd, e_dma,e_we,e_addr,e_wd,e_rd}
        vecs[0] = '{1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234};
        vecs[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h3005, 16'hBEEF,
                    1'b1, 1'b1, 16'h3005, 16'hBEEF, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h3005, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b0, 1'b0, 16'h3005, 16'h0000, 16'hBEEF};
        vecs[3] = '{1'b1, 1'b0, 16'h3001, 16'h0000, 1'b1, 1'b0, 16'h3002, 16'h0000,
                    1'b1, 1'b0, 16'h3002, 16'h0000, 16'h1436};
        vecs[4] = '{1'b1, 1'b1, 16'h3010, 16'h1111, 1'b1, 1'b0, 16'h3005, 16'h0000,
                    1'b0, 1'b1, 16'h3010, 16'h1111, 16'hBEEF};
        vecs[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h3010, 16'h0000,
                    1'b1, 1'b0, 16'h3010, 16'h0000, 16'h1111};
        vecs[6] = '{1'b1, 1'b1, 16'h30FF, 16'hCAFE, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b0, 1'b1, 16'h30FF, 16'hCAFE, 16'hBEEF};
        vecs[7] = '{1'b1, 1'b0, 16'h30FF, 16'h0000, 1'b1, 1'b0, 16'h30FF, 16'h0000,
                    1'b1, 1'b0, 16'h30FF, 16'h0000, 16'hCAFE};

        rst = 1'b1;
`ifdef LC3_MEM_ACV_EN
        psr_user = 1'b0;
`endif
        set_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
        set_dma(1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        tick();
        chk("rst/cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst/dma_rdata", 32'(bus.dma_rdata), 32'd0);
        chk("rst/done", 32'(bus.cpu_ready | bus.dma_ack), 32'd0);
        chk("rst/mem", 32'({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            set_cpu(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wd);
            set_dma(vecs[i].d_req, vecs[i].d_we, vecs[i].d_addr, vecs[i].d_wd);
            run_txn($sformatf("vec%0d", i), vecs[i].e_dma, vecs[i].e_we, vecs[i].e_addr,
                    vecs[i].e_wd, vecs[i].e_rd);
        end

        // Address changed while the access is in flight must not reach the memory.
        set_cpu(1'b1, 1'b0, 16'h3000, 16'h0000);
        tick();
        set_cpu(1'b0, 1'b0, 16'h4000, 16'h0000);
        for (int unsigned i = 0; i <= WS; i++) begin
            if (i != 0) tick();
            chk("hold/addr", 32'(bus.mem_addr), 32'h3000);
        end
        tick();
        chk("hold/ready", 32'(bus.cpu_ready), 32'd1);
        chk("hold/rdata", 32'(bus.cpu_rdata), 32'h1234);
        tick();

        // Reset in the 2nd ACCESS cycle aborts silently; CPU wins the next tie again.
        set_cpu(1'b1, 1'b0, 16'h3020, 16'h0000);
        tick();
        drop_reqs();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst/en", 32'(bus.mem_en), 32'd0);
        chk("midrst/addr", 32'(bus.mem_addr), 32'd0);
        chk("midrst/ready", 32'(bus.cpu_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst/quiet", 32'(bus.cpu_ready | bus.mem_en), 32'd0);
        end
        set_cpu(1'b1, 1'b0, 16'h3001, 16'h0000);
        set_dma(1'b1, 1'b0, 16'h3002, 16'h0000);
        run_txn("midrst/tie", 1'b0, 1'b0, 16'h3001, 16'h0000, 16'h1335);

        // Both requesters held: strict alternation with one IDLE cycle in between.
        do_reset();
        set_cpu(1'b1, 1'b0, 16'h3001, 16'h0000);
        set_dma(1'b1, 1'b0, 16'h3002, 16'h0000);
        n = 0;
        last = 0;
        exp_dma = 1'b0;
        for (int cyc = 1; cyc <= 60 && n < 6; cyc++) begin
            tick();
            if (bus.cpu_ready || bus.dma_ack) begin
                chk("rr/owner", 32'(bus.dma_ack), 32'(exp_dma));
                chk("rr/both", 32'(bus.cpu_ready & bus.dma_ack), 32'd0);
                chk("rr/gap", 32'(cyc - last), (n == 0) ? 32'(WS + 2) : 32'(WS + 3));
                last = cyc;
                exp_dma = !exp_dma;
                n++;
                if (n == 6) drop_reqs();
            end
        end
        chk("rr/count", 32'(n), 32'd6);
        tick();
        chk("rr/idle1", 32'(bus.mem_en), 32'd0);
        tick();
        chk("rr/idle2", 32'(bus.mem_en), 32'd0);

        // Randomized transactions against the transaction-level model.
        do_reset();
        m_last_dma = 1'b1;
        m_cpu_rd = 16'h0000;
        m_dma_rd = 16'h0000;
        for (int it = 0; it < 40; it++) begin
            int unsigned k;
            logic        cwe, dwe, win, wwe;
            logic [15:0] ca, da, cw, dw, wa, wd, erd;
            k = $urandom_range(0, 3);
            if (k == 0) begin
                drop_reqs();
                tick();
                chk("rand/idle", 32'(bus.mem_en | bus.cpu_ready | bus.dma_ack), 32'd0);
            end else begin
                cwe = 1'($urandom_range(0, 1));
                dwe = 1'($urandom_range(0, 1));
                ca  = 16'h3080 + 16'($urandom_range(0, 126));
                da  = 16'h3080 + 16'($urandom_range(0, 126));
                cw  = 16'($urandom);
                dw  = 16'($urandom);
                set_cpu((k & 1) != 0, cwe, ca, cw);
                set_dma((k & 2) != 0, dwe, da, dw);
                win = (k == 3) ? !m_last_dma : (k == 2);
                m_last_dma = win;
                wwe = win ? dwe : cwe;
                wa  = win ? da : ca;
                wd  = win ? dw : cw;
                if (wwe) begin
                    m_mem[wa] = wd;
                end else begin
                    erd = m_mem.exists(wa) ? m_mem[wa] : pat(wa);
                    if (win) m_dma_rd = erd;
                    else m_cpu_rd = erd;
                end
                run_txn($sformatf("rand%0d", it), win, wwe, wa, wd, win ? m_dma_rd : m_cpu_rd);
            end
        end

`ifdef LC3_MEM_ACV_EN
        // Supervisor access to device space is normal; user access traps.
        psr_user = 1'b0;
        set_cpu(1'b1, 1'b0, 16'hFE00, 16'h0000);
        run_txn("acv/super", 1'b0, 1'b0, 16'hFE00, 16'h0000, pat(16'hFE00));
        psr_user = 1'b1;
        set_cpu(1'b1, 1'b0, 16'hFE00, 16'h0000);
        tick();
        drop_reqs();
        chk("acv/en", 32'(bus.mem_en), 32'd0);
        chk("acv/ready", 32'(bus.cpu_ready), 32'd1);
        chk("acv/acv", 32'(acv), 32'd1);
        chk("acv/rdata", 32'(bus.cpu_rdata), 32'd0);
        tick();
        chk("acv/after", 32'(bus.cpu_ready | acv | bus.mem_en), 32'd0);
        psr_user = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lc3_mem_arb.md
Name: lc3_mem_arb

Overview:
- Single-port memory arbiter and wait-state sequencer for the LC-3 core.
- Shares one synchronous memory between two requesters:
  - the CPU's MAR/MDR path: MIO_EN/RW from the control FSM, with R returned;
  - a DMA/loader port used for program load and debug.
- Generates the CPU memory-ready signal R after a programmable number of wait states.
- Sits between the memory-register block and the memory array.

Parameters:
- WAIT_STATES, 2: extra ACCESS cycles per transaction. Legal range 0..15. ACCESS lasts WAIT_STATES+1 cycles.
- AW, 16: address width.
- DW, 16: data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request (MIO_EN)
- cpu_we  in  1  1 = write, 0 = read (RW)
- cpu_addr  in  AW  CPU address (MAR)
- cpu_wdata  in  DW  CPU write data (MDR)
- cpu_rdata  out  DW  CPU read data, registered
- cpu_ready  out  1  one-cycle completion pulse (R)
- dma_req  in  1  DMA access request
- dma_we  in  1  DMA write enable
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_rdata  out  DW  DMA read data, registered
- dma_ack  out  1  one-cycle DMA completion pulse
- mem_en  out  1  memory enable
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid in ACCESS cycles

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; wait counter 0;
  - owner register = CPU; last_grant = DMA, so the CPU wins the first tie.
- FSM transitions:
  - IDLE: if any request is high, grant and go to ACCESS; otherwise stay.
  - ACCESS: counter counts 0..WAIT_STATES, then go to RESP.
  - RESP: one cycle, then IDLE.
- Arbitration, evaluated in IDLE only:
  - single requester: it wins;
  - both requesting: round-robin, the winner is the opposite of last_grant;
  - last_grant updates on every grant.
- Grant latching: on the granting edge, owner, we, addr and wdata are latched. Requester inputs are ignored until the next IDLE.
- Memory outputs:
  - ACCESS: mem_en=1; mem_addr/mem_wdata driven from latches; mem_we = latched we.
  - IDLE and RESP: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
- Read capture: for reads, mem_rdata is captured into the owner's rdata register at the final ACCESS edge. Writes leave rdata unchanged.
- Completion: in RESP, the owner's ready/ack is 1 for exactly one cycle.
- Latency: with the request seen in IDLE at cycle 0, ready rises at cycle WAIT_STATES+2. With WAIT_STATES=2, ready is high in cycle 4.
- Back-to-back: every transaction passes through one IDLE cycle. A requester holding req in the cycle after its ready gets a new transaction, so requesters must drop req after ready.
- Request withdrawn mid-transaction: the transaction still completes and ready/ack still pulses.
- Reset mid-operation: the next edge forces IDLE. No ready/ack is issued and memory outputs drop to 0 in the cycle after reset.
- Counter: width 4. It never wraps past WAIT_STATES and clears on entry to ACCESS.

Optional Feature:
- Macro: LC3_MEM_ACV_EN.
- When defined, two extra ports are added:
  - psr_user (in 1), PSR[15];
  - acv (out 1), reset 0.
- Violation: a CPU grant with psr_user=1 and cpu_addr in x0000–x2FFF or xFE00–xFFFF.
- On a violation:
  - the FSM goes IDLE→RESP directly; mem_en never asserts;
  - cpu_rdata is set to 0;
  - cpu_ready and acv pulse together for one cycle.
- DMA accesses are never checked.
- When not defined, the ports are absent and all CPU accesses proceed normally.

Test Plan:
- Reset, then CPU read of x3000 with mem_rdata=x1234 and WAIT_STATES=2 → mem_en high in cycles 1–3, cpu_ready pulse in cycle 4, cpu_rdata=x1234, dma_ack never asserts.
- DMA write x3005←xBEEF → mem_we high for 3 cycles with mem_addr=x3005 and mem_wdata=xBEEF, dma_ack one cycle, dma_rdata unchanged.
- cpu_req and dma_req asserted together and held for 3 transactions each → grant order CPU, DMA, CPU, DMA, CPU, DMA, with exactly one IDLE cycle between transactions.
- cpu_addr changed from x3000 to x4000 during ACCESS → mem_addr stays x3000 through ACCESS.
- rst asserted in the 2nd ACCESS cycle → next cycle state IDLE, mem_en=0, no cpu_ready, and the CPU wins the next simultaneous request.
- With LC3_MEM_ACV_EN: user-mode CPU read of xFE00 → no mem_en, cpu_ready and acv pulse in cycle 1, cpu_rdata=0. Same read with psr_user=0 → normal 4-cycle access.
